// File: rtl/mem_sram_ctrl_if.sv
// CPU-side load/store bus plus the 16-bit asynchronous SRAM pins.
// The master side is the pipeline and SRAM device; the slave side is the controller.
interface mem_sram_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/mem_sram_ctrl.sv
// Splits each 32-bit CPU load/store into two 16-bit SRAM accesses (low half, then high half),
// each held WAIT_CYCLES+1 cycles, and freezes the pipeline via ready until the word completes.
module mem_sram_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic           clk,
    input  logic           rst,
    mem_sram_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0]  LAST = 4'(WAIT_CYCLES);
    localparam logic [31:0] BASE = 32'(BASE_ADDR);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        is_wr;
    logic [16:0] idx_q;
    logic [31:0] data_q;
    logic [31:0] read_data_q;
    logic        req;
    logic        phase_end;

    assign req       = bus.wr_en | bus.rd_en;
    assign phase_end = (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = LOW;
            LOW:     if (phase_end) state_nxt = HIGH;
            HIGH:    if (phase_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address wraps modulo 2^17 words; byte offset and upper bits are dropped by the cast.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= 4'd0;
            is_wr       <= 1'b0;
            idx_q       <= 17'd0;
            data_q      <= 32'd0;
            read_data_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (req) begin
                        is_wr  <= bus.wr_en;
                        idx_q  <= 17'((bus.address - BASE) >> 2);
                        data_q <= bus.write_data;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        cnt <= 4'd0;
                        if (!is_wr) read_data_q[15:0] <= bus.sram_dq_in;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        cnt <= 4'd0;
                        if (!is_wr) read_data_q[31:16] <= bus.sram_dq_in;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: cnt <= 4'd0;
            endcase
        end
    end

    // Strobes decode straight from state so a reset releases the bus in the same cycle.
    always_comb begin
        bus.sram_addr   = 18'd0;
        bus.sram_dq_out = 16'd0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        bus.ready       = 1'b0;
        case (state)
            IDLE: bus.ready = !req;
            LOW: begin
                bus.sram_addr = {idx_q, 1'b0};
                if (is_wr) begin
                    bus.sram_dq_out = data_q[15:0];
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = 1'b0;
                end
            end
            HIGH: begin
                bus.sram_addr = {idx_q, 1'b1};
                if (is_wr) begin
                    bus.sram_dq_out = data_q[31:16];
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = 1'b0;
                end
            end
            DONE: bus.ready = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    assign bus.read_data = read_data_q;
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed and random load/store sequences against a word-level memory model and an SRAM device model.
module tb_mem_sram_ctrl;
    localparam int WAIT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_sram_ctrl_if bus ();
    mem_sram_ctrl_if bus0 ();

    mem_sram_ctrl #(.WAIT_CYCLES(WAIT), .BASE_ADDR(1024)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    mem_sram_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(1024)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    // SRAM device models (one writer process each; preload port for setup)
    logic [15:0] mem  [0:262143];
    logic [15:0] mem0 [0:262143];
    logic        pl_en = 1'b0;
    logic        pl_sel = 1'b0;
    logic [17:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en && !pl_sel) mem[pl_addr] <= pl_data;
        else if (!bus.sram_we_n && bus.sram_dq_oe) mem[bus.sram_addr] <= bus.sram_dq_out;
    end
    always @(posedge clk) begin
        if (pl_en && pl_sel) mem0[pl_addr] <= pl_data;
        else if (!bus0.sram_we_n && bus0.sram_dq_oe) mem0[bus0.sram_addr] <= bus0.sram_dq_out;
    end
    assign bus.sram_dq_in  = mem[bus.sram_addr];
    assign bus0.sram_dq_in = mem0[bus0.sram_addr];

    // Word-level reference: CPU word index -> 32-bit value
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rd = 32'd0;
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input int i);
        return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
    endfunction

    function automatic logic [16:0] word_idx(input logic [31:0] a);
        logic [31:0] eff;
        eff = a - 32'd1024;
        return 17'(eff / 4);
    endfunction

    task automatic preload(input bit sel, input logic [17:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_sel = sel; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_we_n"}, bus.sram_we_n, 1'b1);
        chk({tag, "_oe"}, bus.sram_dq_oe, 1'b0);
        chk({tag, "_addr"}, bus.sram_addr, 18'd0);
        chk({tag, "_dq_out"}, bus.sram_dq_out, 16'd0);
    endtask

    task automatic idle(input int n);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            chk("idle_ready", bus.ready, 1'b1);
            chk("idle_rd_hold", bus.read_data, exp_rd);
            chk_quiet("idle");
        end
    endtask

    // Cycle 0 is the IDLE cycle holding the request; returns in the DONE cycle.
    task automatic run_op(input bit from_done, input bit w, input bit r,
                          input logic [31:0] a, input logic [31:0] d);
        int          lat;
        bit          wr;
        logic [16:0] idx;
        lat = 2 * (WAIT + 1) + 1;
        wr  = w;
        idx = word_idx(a);
        bus.wr_en = w; bus.rd_en = r; bus.address = a; bus.write_data = d;
        if (from_done) begin @(posedge clk); #1; end
        else #1;
        chk("req_ready", bus.ready, 1'b0);
        chk_quiet("req");
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            if (c < lat) begin
                bit hi;
                hi = (c > WAIT + 1);
                chk("busy_ready", bus.ready, 1'b0);
                chk("busy_addr", bus.sram_addr, {idx, hi});
                chk("busy_we_n", bus.sram_we_n, !wr);
                chk("busy_oe", bus.sram_dq_oe, wr);
                chk("busy_dq_out", bus.sram_dq_out, wr ? (hi ? d[31:16] : d[15:0]) : 16'h0);
                if (wr) chk("wr_rd_hold", bus.read_data, exp_rd);
            end
        end
        if (wr) ref_mem[int'(idx)] = d;
        else    exp_rd = ref_rd(int'(idx));
        chk("done_ready", bus.ready, 1'b1);
        chk("done_read_data", bus.read_data, exp_rd);
        chk_quiet("done");
    endtask

    initial begin
        bus.wr_en = 0; bus.rd_en = 0; bus.address = 0; bus.write_data = 0;
        bus0.wr_en = 0; bus0.rd_en = 0; bus0.address = 0; bus0.write_data = 0;

        preload(0, 18'd2, 16'hBEEF);
        preload(0, 18'd3, 16'hCAFE);
        preload(0, 18'd9, 16'h7777);
        preload(1, 18'h3FFFE, 16'h1111);
        preload(1, 18'h3FFFF, 16'h2222);
        ref_mem[1] = 32'hCAFEBEEF;

        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_read_data", bus.read_data, 32'h0);
        chk_quiet("rst");
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(0, 1, 0, 32'd1024, 32'h12345678);
        idle(1);
        run_op(0, 0, 1, 32'd1028, 32'h0);
        idle(2);
        run_op(0, 1, 0, 32'd1032, 32'h0BADF00D);
        run_op(1, 0, 1, 32'd1032, 32'h0);
        idle(1);
        run_op(0, 1, 1, 32'd1024, 32'h0000A5A5);
        idle(1);
        run_op(0, 0, 1, 32'd1024, 32'h0);
        idle(1);

        // random traffic in words 8..23, seeded by writing every word first
        for (int k = 0; k < 16; k++) begin
            run_op(0, 1, 0, 32'd1056 + 32'(4 * k), $urandom);
            idle(1);
        end
        for (int k = 0; k < 40; k++) begin
            bit w, r, b2b;
            logic [31:0] a;
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            a = 32'd1056 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            b2b = (k > 0) && ($urandom_range(0, 1) == 1);
            if (!b2b && k > 0) idle($urandom_range(1, 3));
            run_op(b2b, w, r, a, $urandom);
        end
        idle(1);

        // reset in the first HIGH cycle of a write to 1040 (SRAM 8/9)
        bus.wr_en = 1; bus.rd_en = 0; bus.address = 32'd1040; bus.write_data = 32'hDEADBEEF;
        for (int c = 1; c <= 4; c++) begin @(posedge clk); #1; end
        chk("pre_abort_we_n", bus.sram_we_n, 1'b0);
        chk("pre_abort_addr", bus.sram_addr, 18'd9);
        rst = 1'b0;
        #1;
        chk("abort_we_n", bus.sram_we_n, 1'b1);
        chk("abort_oe", bus.sram_dq_oe, 1'b0);
        chk("abort_read_data", bus.read_data, 32'h0);
        bus.wr_en = 0;
        #1;
        chk("abort_ready", bus.ready, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        exp_rd = 32'h0;
        ref_mem[4] = 32'h7777BEEF;
        @(posedge clk); #1;
        chk("post_rst_ready", bus.ready, 1'b1);
        chk_quiet("post_rst");
        chk("high_half_kept", mem[9], 16'h7777);
        chk("low_half_written", mem[8], 16'hBEEF);
        run_op(0, 0, 1, 32'd1040, 32'h0);
        idle(1);

        // WAIT_CYCLES=0 instance: read 1023 wraps to word 0x1FFFF
        bus0.rd_en = 1; bus0.address = 32'd1023;
        #1;
        chk("w0_req_ready", bus0.ready, 1'b0);
        @(posedge clk); #1;
        chk("w0_low_addr", bus0.sram_addr, 18'h3FFFE);
        chk("w0_low_we_n", bus0.sram_we_n, 1'b1);
        chk("w0_low_ready", bus0.ready, 1'b0);
        @(posedge clk); #1;
        chk("w0_high_addr", bus0.sram_addr, 18'h3FFFF);
        chk("w0_high_oe", bus0.sram_dq_oe, 1'b0);
        @(posedge clk); #1;
        chk("w0_done_ready", bus0.ready, 1'b1);
        chk("w0_read_data", bus0.read_data, 32'h22221111);
        bus0.rd_en = 0;
        @(posedge clk); #1;
        chk("w0_idle_ready", bus0.ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_sram_ctrl.md
MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, extra hold cycles per SRAM half-word access; legal range 0..15.
REQ-002 Parameter BASE_ADDR, default 1024, CPU byte address mapped to SRAM half-word address 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  store request from the EXE/MEM pipeline register.
REQ-006 rd_en  input  1  load request from the EXE/MEM pipeline register.
REQ-007 address  input  32  CPU byte address (ALU result).
REQ-008 write_data  input  32  store data (Val_Rm).
REQ-009 read_data  output  32  load result to MEM stage.
REQ-010 ready  output  1  combinational; 0 = pipeline must freeze.
REQ-011 sram_addr  output  18  SRAM half-word address.
REQ-012 sram_dq_out  output  16  data driven to SRAM.
REQ-013 sram_dq_in  input  16  data returned from SRAM.
REQ-014 sram_dq_oe  output  1  1 = controller drives the data bus.
REQ-015 sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-016 FSM states SHALL be IDLE, LOW, HIGH, DONE.
REQ-017 In IDLE with wr_en|rd_en=1, the block SHALL register address, write_data and op type (write if wr_en=1, else read) and go to LOW on the next edge.
REQ-018 wr_en and rd_en both 1 SHALL be treated as a write.
REQ-019 Effective address SHALL be eff = address - BASE_ADDR (32-bit modulo); word index idx = eff[18:2]; eff[1:0] ignored; higher bits ignored (wrap).
REQ-020 LOW SHALL last WAIT_CYCLES+1 cycles with sram_addr = {idx,1'b0}; HIGH SHALL last WAIT_CYCLES+1 cycles with sram_addr = {idx,1'b1}; a 4-bit phase counter SHALL reset on each phase entry.
REQ-021 For writes: sram_dq_oe=1 and sram_we_n=0 throughout LOW/HIGH; sram_dq_out = data[15:0] in LOW, data[31:16] in HIGH.
REQ-022 For reads: sram_dq_oe=0, sram_we_n=1; sram_dq_in SHALL be captured on the last cycle of LOW into read_data[15:0] and of HIGH into read_data[31:16].
REQ-023 After HIGH, the FSM SHALL enter DONE for exactly one cycle, then IDLE; requests present during DONE SHALL be ignored (the pipeline advances on that edge).
REQ-024 ready SHALL be 1 in DONE, and in IDLE only when wr_en=0 and rd_en=0; 0 otherwise.
REQ-025 Latency: request in IDLE at cycle 0 -> ready=1 at cycle 2*(WAIT_CYCLES+1)+1 (cycle 7 for default).
REQ-026 read_data SHALL update only from read captures and hold its value through writes and idle periods.
REQ-027 Outside LOW/HIGH: sram_we_n=1, sram_dq_oe=0, sram_dq_out=0, sram_addr=0.
REQ-028 Back-to-back requests SHALL be separated by at least one IDLE cycle.

Reset
REQ-029 rst=0 SHALL asynchronously force state IDLE, counter 0, read_data 0, captured registers 0, sram_we_n=1, sram_dq_oe=0, regardless of operation in progress.
REQ-030 A write aborted by reset SHALL deassert sram_we_n in the same cycle; no resume after reset release.

Verification
REQ-031 Write 0x12345678 to 1024, WAIT=2 -> cycles 1-3: sram_addr=0, dq_out=0x5678, we_n=0; cycles 4-6: sram_addr=1, dq_out=0x1234; ready=0 cycles 0-6, 1 at cycle 7.
REQ-032 SRAM model preloaded addr 2=0xBEEF, 3=0xCAFE; read 1028 -> read_data=0xCAFEBEEF at cycle 7, we_n=1 and dq_oe=0 throughout.
REQ-033 Write then read of 1032 with requests held -> one IDLE cycle between ops, read returns written value, read_data unchanged during the write.
REQ-034 wr_en=rd_en=1 at 1024, data 0xA5A5 -> write performed, read_data unchanged.
REQ-035 rst=0 asserted at cycle 4 of a write -> same cycle we_n=1, dq_oe=0, ready=1 once requests drop; SRAM high half not written.
REQ-036 WAIT=0 read -> ready=1 at cycle 3; address 1023 -> idx wraps to 0x1FFFF.
